cache_requester: RTL and testbench

- Client-side controller that drives the K-way CLOCK-replacement cache's read/write/addr/val port and consumes its registered hit/out_val.
- Accepts one load/store at a time from a core over valid/ready. Issues cache lookups and fetches read misses from backing memory over a req/ack handshake.
- Fills the cache by holding write until the cache's eviction sweep reports hit. Stores are write-through.
- Sits between the core and the cache plus backing memory.

---
 rtl/cache_requester.sv | 192 +++++++++++++++++++
 tb/tb_cache_requester.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_requester.sv
// cache_requester: single-outstanding load/store client for the CLOCK cache.
// Loads look up the cache, fetch misses from memory and fill the cache.
// Stores write the cache, then write through to memory.
// Ports: req_* core request (valid/ready), rsp_* core response (valid/ready),
//   cache_* cache lookup/fill port, mem_* backing memory (req/ack),
//   hit_count/miss_count saturating lookup statistics.
module cache_requester #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [LINE_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_hit,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [LINE_WIDTH-1:0] cache_wdata,
  output logic                  cache_read,
  output logic                  cache_write,
  input  logic                  cache_hit,
  input  logic [LINE_WIDTH-1:0] cache_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_RD_ISSUE   = 4'd1;
  localparam logic [3:0] S_RD_CHECK   = 4'd2;
  localparam logic [3:0] S_MEM_RD     = 4'd3;
  localparam logic [3:0] S_FILL_ISSUE = 4'd4;
  localparam logic [3:0] S_FILL_WAIT  = 4'd5;
  localparam logic [3:0] S_WR_ISSUE   = 4'd6;
  localparam logic [3:0] S_WR_WAIT    = 4'd7;
  localparam logic [3:0] S_MEM_WR     = 4'd8;
  localparam logic [3:0] S_RESP       = 4'd9;

  logic [3:0]            state;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] data_q;
  logic                  hit_q;
  logic                  err_q;
  logic [WW-1:0]         wait_q;

  logic [WW-1:0] wait_inc;
  logic          timeout;
  logic          lookup;
  logic          resp;

  assign wait_inc = wait_q + WW'(1);
  assign timeout  = (wait_inc == WW'(MAX_WAIT));
  assign resp     = (state == S_RESP);

  // A store's lookup result is the cache's answer in the first wait cycle.
  assign lookup = (state == S_RD_CHECK) ||
                  ((state == S_WR_WAIT) && (wait_q == '0));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            data_q  <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
            state   <= req_we ? S_WR_ISSUE : S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: state <= S_RD_CHECK;
        S_RD_CHECK: begin
          if (cache_hit) begin
            data_q <= cache_rdata;
            hit_q  <= 1'b1;
            state  <= S_RESP;
          end else begin
            state  <= S_MEM_RD;
          end
        end
        S_MEM_RD: begin
          if (mem_ack) begin
            data_q <= mem_rdata;
            wait_q <= '0;
            state  <= S_FILL_ISSUE;
          end
        end
        // cache_hit in the issue cycle is stale and not looked at.
        S_FILL_ISSUE: begin
          wait_q <= '0;
          state  <= S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          wait_q <= wait_inc;
          if (cache_hit) begin
            state <= S_RESP;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end
        end
        S_WR_ISSUE: begin
          wait_q <= '0;
          state  <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          wait_q <= wait_inc;
          if (wait_q == '0) hit_q <= cache_hit;
          if (cache_hit) begin
            state <= S_MEM_WR;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_MEM_WR;
          end
        end
        S_MEM_WR: begin
          if (mem_ack) state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            data_q <= '0;
            hit_q  <= 1'b0;
            err_q  <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookup) begin
      if (cache_hit) begin
        if (~&hit_count) hit_count <= hit_count + CNT_WIDTH'(1);
      end else begin
        if (~&miss_count) miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    req_ready   = (state == S_IDLE);
    rsp_valid   = resp;
    rsp_rdata   = (resp && !we_q) ? data_q : '0;
    rsp_hit     = resp & hit_q;
    rsp_err     = resp & err_q;
    cache_addr  = addr_q;
    mem_addr    = addr_q;
    cache_read  = (state == S_RD_ISSUE);
    cache_write = (state == S_FILL_ISSUE) || (state == S_FILL_WAIT) ||
                  (state == S_WR_ISSUE)   || (state == S_WR_WAIT);
    cache_wdata = '0;
    if (cache_write) cache_wdata = we_q ? wdata_q : data_q;
    mem_req     = (state == S_MEM_RD) || (state == S_MEM_WR);
    mem_we      = (state == S_MEM_WR);
    mem_wdata   = (state == S_MEM_WR) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_cache_requester.sv
// tb_cache_requester: table vectors, corner sequences and random traffic
// for cache_requester, with a transaction-level expectation model.
module tb_cache_requester;

  localparam int AW   = 8;
  localparam int LW   = 32;
  localparam int MAXW = 16;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [LW-1:0] rsp_rdata;
  logic          rsp_hit, rsp_err;
  logic [AW-1:0] cache_addr;
  logic [LW-1:0] cache_wdata;
  logic          cache_read, cache_write, cache_hit;
  logic [LW-1:0] cache_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clock = ~clock;

  cache_requester #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
    .MAX_WAIT(MAXW), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    bit            lookup_hit;
    logic [LW-1:0] cdata;
    int            mem_lat;
    logic [LW-1:0] mdata;
    int            fill_wait;
    int            rsp_delay;
    bit            hold;
    int            e_lat;
    logic [LW-1:0] e_rdata;
    bit            e_hit;
    bit            e_err;
    int            e_writes;
    int            e_mem;
  } vec_t;

  typedef struct {
    bit            done;
    int            lat;
    logic [LW-1:0] rdata;
    bit            hit;
    bit            err;
    int            writes;
    int            mem;
    int            reads;
    bit            stable;
    bit            inv;
    bit            addr_ok;
    bit            wd_ok;
    bit            mem_ok;
    bit            rdy_ok;
    bit            idle;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int m_hits = 0;
  int m_miss = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    bit we, logic [AW-1:0] addr, logic [LW-1:0] wdata, bit lh,
    logic [LW-1:0] cdata, int ml, logic [LW-1:0] mdata, int fw,
    int rd, bit hold, int e_lat, logic [LW-1:0] e_rdata, bit e_hit,
    bit e_err, int e_wr, int e_mem);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.lookup_hit = lh;
    v.cdata = cdata; v.mem_lat = ml; v.mdata = mdata;
    v.fill_wait = fw; v.rsp_delay = rd; v.hold = hold;
    v.e_lat = e_lat; v.e_rdata = e_rdata; v.e_hit = e_hit;
    v.e_err = e_err; v.e_writes = e_wr; v.e_mem = e_mem;
    return v;
  endfunction

  // Expected outcome from the operation's timing rules.
  function automatic vec_t model(vec_t v);
    vec_t e = v;
    bit   ok = (v.fill_wait >= 1) && (v.fill_wait <= MAXW);
    int   waits = ok ? v.fill_wait : MAXW;
    if (!v.we && v.lookup_hit) begin
      e.e_lat = 3; e.e_rdata = v.cdata; e.e_hit = 1'b1;
      e.e_err = 1'b0; e.e_writes = 0; e.e_mem = 0;
    end else if (!v.we) begin
      e.e_mem = v.mem_lat + 1; e.e_writes = 1 + waits;
      e.e_lat = 2 + e.e_mem + e.e_writes + 1;
      e.e_rdata = v.mdata; e.e_hit = 1'b0; e.e_err = !ok;
    end else begin
      e.e_mem = v.mem_lat + 1; e.e_writes = 1 + waits;
      e.e_lat = e.e_writes + e.e_mem + 1;
      e.e_rdata = '0; e.e_hit = (v.fill_wait == 1); e.e_err = !ok;
    end
    return e;
  endfunction

  // Plays core, cache and memory for one operation; called #1 after an
  // edge with the DUT idle, returns #1 after the response handshake edge.
  task automatic run(input vec_t v, output obs_t o);
    int cyc = 0, c = 0, m = 0, r = 0;
    bit prev_read = 0;
    o = '{default: 0};
    o.stable = 1; o.inv = 1; o.addr_ok = 1;
    o.wd_ok = 1; o.mem_ok = 1; o.rdy_ok = 1;
    req_valid = 1'b1; req_we = v.we;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clock); #1;
    if (!v.hold) req_valid = 1'b0;
    while (!o.done && cyc < 300) begin
      cyc++;
      if (req_ready) o.rdy_ok = 0;
      if (cache_read && cache_write) o.inv = 0;
      if (mem_req && cache_write) o.inv = 0;
      if (cache_addr !== v.addr || mem_addr !== v.addr) o.addr_ok = 0;
      if (cache_read) o.reads++;
      if (cache_write) begin
        c++; o.writes++;
        if (cache_wdata !== (v.we ? v.wdata : v.mdata)) o.wd_ok = 0;
      end else c = 0;
      if (prev_read) begin
        cache_hit = v.lookup_hit; cache_rdata = v.cdata;
      end else if (cache_write) begin
        cache_hit = (c == 1) ? 1'b1 : (c - 1 == v.fill_wait);
        cache_rdata = $urandom;
      end else begin
        cache_hit = 1'($urandom_range(0, 1)); cache_rdata = $urandom;
      end
      if (mem_req) begin
        m++; o.mem++;
        if (mem_we !== v.we || (v.we && mem_wdata !== v.wdata)) o.mem_ok = 0;
        mem_ack = (m == v.mem_lat + 1);
        mem_rdata = mem_ack ? v.mdata : $urandom;
      end else begin
        m = 0; mem_ack = rsp_valid || prev_read; mem_rdata = $urandom;
      end
      prev_read = cache_read;
      rsp_ready = 1'b0;
      if (rsp_valid) begin
        r++;
        if (r == 1) begin
          o.lat = cyc; o.rdata = rsp_rdata;
          o.hit = rsp_hit; o.err = rsp_err;
        end else if ({rsp_rdata, rsp_hit, rsp_err} !==
                     {o.rdata, o.hit, o.err}) o.stable = 0;
        rsp_ready = (r > v.rsp_delay);
        o.done = rsp_ready;
      end
      @(posedge clock); #1;
    end
    rsp_ready = 1'b0; mem_ack = 1'b0; cache_hit = 1'b0;
    o.idle = req_ready;
  endtask

  task automatic apply(input vec_t v, input string t);
    obs_t o;
    run(v, o);
    chk({t, " done"}, 64'(o.done), 64'(1));
    chk({t, " lat"}, 64'(o.lat), 64'(v.e_lat));
    if (v.we || !v.e_err) chk({t, " rdata"}, 64'(o.rdata), 64'(v.e_rdata));
    chk({t, " hit"}, 64'(o.hit), 64'(v.e_hit));
    chk({t, " err"}, 64'(o.err), 64'(v.e_err));
    chk({t, " writes"}, 64'(o.writes), 64'(v.e_writes));
    chk({t, " memcyc"}, 64'(o.mem), 64'(v.e_mem));
    chk({t, " reads"}, 64'(o.reads), 64'(v.we ? 0 : 1));
    chk({t, " stable"}, 64'(o.stable), 64'(1));
    chk({t, " excl"}, 64'(o.inv), 64'(1));
    chk({t, " addr"}, 64'(o.addr_ok), 64'(1));
    chk({t, " cwdata"}, 64'(o.wd_ok), 64'(1));
    chk({t, " memdata"}, 64'(o.mem_ok), 64'(1));
    chk({t, " busy"}, 64'(o.rdy_ok), 64'(1));
    chk({t, " idle"}, 64'(o.idle), 64'(1));
    if (v.e_hit) m_hits = (m_hits == SAT) ? SAT : m_hits + 1;
    else         m_miss = (m_miss == SAT) ? SAT : m_miss + 1;
    chk({t, " hit_count"}, 64'(hit_count), 64'(m_hits));
    chk({t, " miss_count"}, 64'(miss_count), 64'(m_miss));
  endtask

  vec_t tbl[10];
  vec_t rv;
  bit   saw;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    cache_hit = 1'b0; cache_rdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst req_ready", 64'(req_ready), 64'(1));
    chk("rst outputs", 64'({rsp_valid, rsp_hit, rsp_err, cache_read,
        cache_write, mem_req, mem_we}), 64'(0));
    chk("rst data", 64'({rsp_rdata, cache_addr}), 64'(0));
    chk("rst counts", 64'({hit_count, miss_count}), 64'(0));
    reset_n = 1'b1;

    //        we addr   wdata          lh cdata          ml mdata          fw  rd hold  lat rdata         h  e  wr mem
    tbl[0] = mk(0, 8'h10, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0,  0, 0,    3, 32'hDEADBEEF, 1, 0, 0,  0);
    tbl[1] = mk(0, 8'h20, 32'h0,        0, 32'h0,        2, 32'h12345678, 2,  0, 0,    9, 32'h12345678, 0, 0, 3,  3);
    tbl[2] = mk(1, 8'h30, 32'hCAFEF00D, 0, 32'h0,        0, 32'h0,        1,  0, 0,    4, 32'h0,        1, 0, 2,  1);
    tbl[3] = mk(0, 8'h40, 32'h0,        0, 32'h0,        0, 32'h0BADF00D, 0,  0, 0,   21, 32'h0BADF00D, 0, 1, 17, 1);
    tbl[4] = mk(0, 8'h50, 32'h0,        1, 32'h55AA55AA, 0, 32'h0,        0,  5, 1,    3, 32'h55AA55AA, 1, 0, 0,  0);
    tbl[5] = mk(1, 8'h60, 32'h11223344, 0, 32'h0,        1, 32'h0,        0,  0, 0,   20, 32'h0,        0, 1, 17, 2);
    tbl[6] = mk(0, 8'h70, 32'h0,        0, 32'h0,        0, 32'hA5A5A5A5, 2,  0, 0,    7, 32'hA5A5A5A5, 0, 0, 3,  1);
    tbl[7] = mk(0, 8'h80, 32'h0,        0, 32'h0,        1, 32'hFEEDFACE, 16, 0, 0,   22, 32'hFEEDFACE, 0, 0, 17, 2);
    tbl[8] = mk(1, 8'h90, 32'h01020304, 0, 32'h0,        0, 32'h0,        3,  0, 0,    6, 32'h0,        0, 0, 4,  1);
    tbl[9] = mk(0, 8'hA0, 32'h0,        0, 32'h0,        0, 32'h77777777, 17, 1, 0,   21, 32'h77777777, 0, 1, 17, 1);
    for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting on memory for a read miss.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'hC3;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    cache_hit = 1'b0; mem_ack = 1'b0;
    @(posedge clock); #1;
    chk("mid mem_req", 64'(mem_req), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("arst mem_req", 64'({mem_req, cache_write}), 64'(0));
    chk("arst req_ready", 64'(req_ready), 64'(1));
    chk("arst counts", 64'({hit_count, miss_count}), 64'(0));
    @(posedge clock); #1;
    reset_n = 1'b1;
    saw = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      if (rsp_valid || !req_ready) saw = 1;
    end
    chk("post-rst quiet", 64'(saw), 64'(0));
    m_hits = 0; m_miss = 0;

    for (int i = 0; i < 40; i++) begin
      rv.we = 1'($urandom_range(0, 1));
      rv.addr = AW'($urandom); rv.wdata = $urandom;
      rv.lookup_hit = 1'($urandom_range(0, 1));
      rv.cdata = $urandom; rv.mdata = $urandom;
      rv.mem_lat = $urandom_range(0, 3);
      rv.fill_wait = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(0, 18);
      rv.rsp_delay = $urandom_range(0, 3);
      rv.hold = 1'b0;
      apply(model(rv), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
